// File: rtl/myproject_mul_share_arb.sv
// Round-robin share of one external 13s x 18s multiplier among NUM_REQ lanes.
// Operands are registered into the multiplier; product and lane id are registered out.
module myproject_mul_share_arb #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2,
   parameter int A_WIDTH  = 13,
   parameter int B_WIDTH  = 18,
   parameter int P_WIDTH  = 29
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
   output logic [A_WIDTH-1:0]           mul_din0,
   output logic [B_WIDTH-1:0]           mul_din1,
   input  logic [P_WIDTH-1:0]           mul_dout,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [P_WIDTH-1:0]           res_p,
   output logic [ID_WIDTH-1:0]          res_id
);

   localparam logic [ID_WIDTH:0] NREQ = (ID_WIDTH+1)'(NUM_REQ);

   if (ID_WIDTH != $clog2(NUM_REQ)) begin : g_bad_id_width
      $error("ID_WIDTH must equal clog2(NUM_REQ)");
   end

   logic                s1_valid;
   logic [ID_WIDTH-1:0] s1_id;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic                s2_ready;
   logic                s1_ready;
   logic                found;
   logic [ID_WIDTH-1:0] gidx;
   logic [ID_WIDTH-1:0] cand;
   logic                accept;

   function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH:0] v);
      logic [ID_WIDTH:0] r;
      r = (v >= NREQ) ? v - NREQ : v;
      return r[ID_WIDTH-1:0];
   endfunction

   assign s2_ready = !res_valid || res_ready;
   assign s1_ready = !s1_valid || s2_ready;

   // First valid index at or after rr_ptr, wrapping around
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_idx({1'b0, rr_ptr} + (ID_WIDTH+1)'(k));
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (ap_rst_n && found) begin
         req_ready[gidx] = s1_ready;
      end
   end

   assign accept = ap_rst_n && found && s1_ready;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         rr_ptr    <= '0;
         mul_din0  <= '0;
         mul_din1  <= '0;
         res_valid <= 1'b0;
         res_p     <= '0;
         res_id    <= '0;
      end else begin
         if (s2_ready) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
               res_p  <= mul_dout;
               res_id <= s1_id;
            end
         end
         if (s1_ready) begin
            s1_valid <= accept;
            if (accept) begin
               mul_din0 <= req_a[gidx*A_WIDTH +: A_WIDTH];
               mul_din1 <= req_b[gidx*B_WIDTH +: B_WIDTH];
               s1_id    <= gidx;
               rr_ptr   <= wrap_idx({1'b0, gidx} + (ID_WIDTH+1)'(1));
            end
         end
      end
   end

endmodule
